// File: rtl/capture_arbiter.sv
// Round-robin arbiter sharing one capture register among NREQ requesters,
// with a post-capture guard window and clear/set overrides on the held word.
module capture_arbiter #(
   parameter int NREQ     = 4,
   parameter int DW       = 21,
   parameter int BITSEL   = 7,
   parameter int HOLD_CYC = 3
) (
   input  logic               clkin_data,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic               clr_req,
   input  logic               set_req,
   output logic [NREQ-1:0]    grant,
   output logic [DW-1:0]      q,
   output logic               out_bit,
   output logic               any_set,
   output logic               busy,
   output logic               done
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD} state_t;

   state_t            r_state, w_state_nxt;
   logic [NREQ-1:0]   r_grant, w_grant_nxt;
   logic [DW-1:0]     r_q, w_q_nxt;
   logic [3:0]        r_cnt, w_cnt_nxt;
   logic [PW-1:0]     r_ptr, w_ptr_nxt;
   logic              r_done, w_done_nxt;

   logic [NREQ-1:0]   w_rot, w_rot_oh, w_win_oh;
   logic [PW-1:0]     w_gidx, w_ptr_adv;
   logic [DW-1:0]     w_sel;
   logic [NREQ-1:0][DW-1:0] w_or;
   logic [NREQ-1:0][PW-1:0] w_enc;

   // Rotate requests so r_ptr sits at bit 0, take the lowest set bit, rotate back.
   assign w_rot    = NREQ'({req, req} >> r_ptr);
   assign w_rot_oh = w_rot & (~w_rot + NREQ'(1));
   assign w_win_oh = NREQ'(((2*NREQ)'({w_rot_oh, w_rot_oh} << r_ptr)) >> NREQ);

   // The registered one-hot grant selects the word and encodes the winner index.
   for (genvar g = 0; g < NREQ; g++) begin : g_mux
      if (g == 0) begin : g_first
         assign w_or[g]  = r_grant[g] ? req_data[g*DW +: DW] : '0;
         assign w_enc[g] = '0;
      end else begin : g_rest
         assign w_or[g]  = w_or[g-1] | (r_grant[g] ? req_data[g*DW +: DW] : '0);
         assign w_enc[g] = w_enc[g-1] | (r_grant[g] ? PW'(g) : '0);
      end
   end

   assign w_sel     = w_or[NREQ-1];
   assign w_gidx    = w_enc[NREQ-1];
   assign w_ptr_adv = (w_gidx == PW'(NREQ-1)) ? '0 : w_gidx + PW'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = '0;
      w_q_nxt     = r_q;
      w_cnt_nxt   = r_cnt;
      w_ptr_nxt   = r_ptr;
      w_done_nxt  = 1'b0;
      if (clr_req || set_req) begin
         // Overrides abort any transaction; a pending capture is dropped.
         w_q_nxt     = clr_req ? '0 : '1;
         w_cnt_nxt   = '0;
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|req) begin
                  w_grant_nxt = w_win_oh;
                  w_state_nxt = S_GRANT;
               end
            end
            S_GRANT: begin
               w_q_nxt     = w_sel;
               w_cnt_nxt   = 4'(HOLD_CYC);
               w_ptr_nxt   = w_ptr_adv;
               w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
               if (r_cnt == 4'd1) begin
                  w_done_nxt  = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt - 4'd1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clkin_data) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_q     <= '0;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_q     <= w_q_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ptr   <= w_ptr_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign grant   = r_grant;
   assign q       = r_q;
   assign out_bit = r_q[BITSEL];
   assign any_set = |r_q;
   assign busy    = (r_state == S_GRANT) || (r_state == S_HOLD);
   assign done    = r_done;
endmodule

// File: tb/tb_capture_arbiter.sv
// Bench for capture_arbiter: vector table of round-robin transactions plus
// hand-written override/reset sequences; grants checked through a queue.
module tb_capture_arbiter;
   localparam int NREQ = 4, DW = 21, BITSEL = 7, HOLD_CYC = 3;

   logic               clk = 1'b0;
   logic               rst, clr_req, set_req;
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    grant;
   logic [DW-1:0]      q;
   logic               out_bit, any_set, busy, done;
   logic [DW-1:0]      d [NREQ];

   int checks = 0, errors = 0, cyc = 0;
   logic [NREQ-1:0] gq[$];

   typedef struct {
      logic [NREQ-1:0] req;
      int              idx;
      logic [DW-1:0]   expq;
   } vec_t;
   vec_t vt[10];

   capture_arbiter #(.NREQ(NREQ), .DW(DW), .BITSEL(BITSEL), .HOLD_CYC(HOLD_CYC)) dut (
      .clkin_data(clk), .rst(rst), .req(req), .req_data(req_data),
      .clr_req(clr_req), .set_req(set_req), .grant(grant), .q(q),
      .out_bit(out_bit), .any_set(any_set), .busy(busy), .done(done));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign req_data = {d[3], d[2], d[1], d[0]};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Every grant pulse must match the next expected one-hot pushed by the stimulus.
   always @(posedge clk) begin
      #1;
      if (grant !== '0) begin
         if (gq.size() == 0) chk("grant_unexpected", 32'(grant), 32'h0);
         else                chk("grant_sb", 32'(grant), 32'(gq.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_grant(input string nm);
      int n = 0;
      do begin tick(); n++; end while (grant === '0 && n < 8);
      chk(nm, 32'(n), 32'd1);
   endtask

   task automatic xact(input logic [NREQ-1:0] rv, input int idx, input logic [DW-1:0] eq,
                       output int gcyc);
      int n;
      req = rv;
      gq.push_back(NREQ'(1) << idx);
      wait_grant("grant_latency");
      gcyc = cyc;
      tick();
      chk("grant_pulse", 32'(grant), 32'h0);
      chk("q_capture", 32'(q), 32'(eq));
      chk("out_bit", 32'(out_bit), 32'(eq[BITSEL]));
      chk("any_set", 32'(any_set), 32'(|eq));
      chk("busy_hold", 32'(busy), 32'd1);
      n = 0;
      do begin tick(); n++; end while (!done && n < 20);
      chk("done_latency", 32'(n), 32'(HOLD_CYC));
      chk("busy_at_done", 32'(busy), 32'd0);
   endtask

   initial begin
      int gc, prev;
      logic [DW-1:0] ones;
      ones = '1;
      d[0] = 21'h0A5A5; d[1] = 21'h13C3C; d[2] = 21'h15A5A; d[3] = 21'h00F0F;
      vt[0] = '{4'b0100, 2, 21'h15A5A};
      vt[1] = '{4'b1111, 3, 21'h00F0F};
      vt[2] = '{4'b1111, 0, 21'h0A5A5};
      vt[3] = '{4'b1111, 1, 21'h13C3C};
      vt[4] = '{4'b1111, 2, 21'h15A5A};
      vt[5] = '{4'b1111, 3, 21'h00F0F};
      vt[6] = '{4'b1111, 0, 21'h0A5A5};
      vt[7] = '{4'b0001, 0, 21'h0A5A5};
      vt[8] = '{4'b1001, 3, 21'h00F0F};
      vt[9] = '{4'b0110, 1, 21'h13C3C};

      rst = 1'b1; clr_req = 1'b0; set_req = 1'b0; req = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_any_set", 32'(any_set), 32'h0);

      prev = 0;
      for (int i = 0; i < 10; i++) begin
         xact(vt[i].req, vt[i].idx, vt[i].expq, gc);
         if (i > 0 && vt[i].req == 4'b1111 && vt[i-1].req == 4'b1111)
            chk("rr_gap", 32'(gc - prev), 32'(1 + HOLD_CYC + 1));
         prev = gc;
      end
      req = '0;

      // idle with no request: no grant, q retained
      tick(); tick(); tick();
      chk("idle_q_hold", 32'(q), 32'(vt[9].expq));
      chk("idle_busy", 32'(busy), 32'h0);

      // clear during HOLD after an all-ones capture
      d[1] = ones;
      req = 4'b0010; gq.push_back(4'b0010);
      wait_grant("clr_seq_grant");
      tick();
      chk("clr_seq_cap", 32'(q), 32'(ones));
      req = '0; clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      chk("clr_q", 32'(q), 32'h0);
      chk("clr_busy", 32'(busy), 32'h0);
      chk("clr_done", 32'(done), 32'h0);
      xact(4'b0001, 0, 21'h0A5A5, gc);
      req = '0;
      d[1] = 21'h13C3C;

      // clear and set together, then set alone
      clr_req = 1'b1; set_req = 1'b1;
      tick();
      clr_req = 1'b0;
      chk("clr_wins", 32'(q), 32'h0);
      tick();
      set_req = 1'b0;
      chk("set_q", 32'(q), 32'(ones));
      chk("set_out_bit", 32'(out_bit), 32'd1);
      chk("set_any_set", 32'(any_set), 32'd1);

      // set during GRANT discards the capture and keeps the pointer
      clr_req = 1'b1; tick(); clr_req = 1'b0;
      req = 4'b0010; gq.push_back(4'b0010);
      wait_grant("set_seq_grant");
      set_req = 1'b1; req = '0;
      tick();
      set_req = 1'b0;
      chk("set_in_grant_q", 32'(q), 32'(ones));
      chk("set_in_grant_busy", 32'(busy), 32'h0);
      xact(4'b0011, 1, 21'h13C3C, gc);
      req = '0;

      // reset mid-HOLD with set high
      req = 4'b0100; gq.push_back(4'b0100);
      wait_grant("rst_seq_grant");
      tick();
      req = '0; rst = 1'b1; set_req = 1'b1;
      tick();
      rst = 1'b0; set_req = 1'b0;
      chk("rst_mid_q", 32'(q), 32'h0);
      chk("rst_mid_busy", 32'(busy), 32'h0);
      chk("rst_mid_done", 32'(done), 32'h0);
      xact(4'b1111, 0, 21'h0A5A5, gc);
      req = '0;
      tick(); tick();

      chk("sb_empty", 32'(gq.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
